// File: rtl/spi_regbank_pkg.sv
// Shared constants and FSM encoding for the SPI-slave register bank.
package spi_regbank_pkg;

  localparam int         CMD_RD_BIT  = 7;
  localparam int         CMD_INC_BIT = 6;
  localparam logic [5:0] RD_BASE     = 6'h20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

endpackage

// File: rtl/spi_regbank_if.sv
// SPI pin bundle between the host (master) and the register bank (slave).
interface spi_regbank_if;
  logic sck;
  logic ssel;
  logic mosi;
  logic miso;

  modport master (output sck, output ssel, output mosi, input miso);
  modport slave  (input sck, input ssel, input mosi, output miso);
endinterface

// File: rtl/spi_regbank_sync_edge.sv
// Three-flop synchroniser for an asynchronous pin, with optional one-CLK rise/fall pulses.
module spi_sync_edge #(
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [2:0] q;

  // Flops reset to 0 so a chip select already low at reset release never looks like a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= {q[1:0], din};
  end

  assign sync = q[2];

  generate
    if (EDGE_EN) begin : g_edge
      assign rise = q[1] & ~q[2];
      assign fall = ~q[1] & q[2];
    end else begin : g_no_edge
      assign rise = 1'b0;
      assign fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/spi_regbank.sv
// SPI-slave register bank: NCH write channels, NCH snapshotted read channels, DW-bit words.
// Optional macro SPI_REGBANK_AUTOINC_EN enables command bit6 auto-increment with in-region wrap.
module spi_regbank
  import spi_regbank_pkg::*;
#(
  parameter int NCH = 8,
  parameter int DW  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_regbank_if.slave      spi,
  output logic [NCH*DW-1:0] wr_val,
  input  logic [NCH*DW-1:0] rd_val,
  output logic              wr_stb,
  output logic [4:0]        wr_addr
);

  localparam int         NB        = DW / 8;
  localparam logic [1:0] LAST_BYTE = 2'(NB - 1);

  logic sck_rise, sck_fall, ssel_rise, ssel_fall, mosi_s;
  logic sck_s_unused, ssel_s_unused, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.EDGE_EN(1'b1)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .din(spi.sck),
    .sync(sck_s_unused), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.EDGE_EN(1'b1)) u_sync_ssel (
    .clk(clk), .rst_n(rst_n), .din(spi.ssel),
    .sync(ssel_s_unused), .rise(ssel_rise), .fall(ssel_fall)
  );

  spi_sync_edge #(.EDGE_EN(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(spi.mosi),
    .sync(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_t          state, state_nx;
  logic [2:0]      bit_cnt;
  logic [1:0]      byte_cnt;
  logic [5:0]      addr, addr_nx;
  logic            rd_mode;
  logic            skip_shift;
  logic [DW-1:0]   tx;
  logic [DW-2:0]   asm_word;
  logic [NCH*DW-1:0] snap;
  logic            cmd_done, word_done;
  logic [DW-1:0]   word_in;
  logic [5:0]      cmd_addr;
  logic            cmd_rd;

  assign word_in  = {asm_word, mosi_s};
  assign cmd_addr = {asm_word[4:0], mosi_s};
  assign cmd_rd   = asm_word[CMD_RD_BIT-1];

  function automatic logic [DW-1:0] read_word(input logic [5:0] a);
    logic [DW-1:0] w;
    w = '0;
    for (int k = 0; k < NCH; k++) begin
      if (a[4:0] == 5'(k))
        w = (a >= RD_BASE) ? snap[k*DW +: DW] : wr_val[k*DW +: DW];
    end
    return w;
  endfunction

`ifdef SPI_REGBANK_AUTOINC_EN
  logic inc_mode;

  // Advance within the region of the current address; unmapped addresses hold.
  function automatic logic [5:0] next_addr(input logic [5:0] a);
    logic [5:0] base;
    base = (a >= RD_BASE) ? RD_BASE : 6'h00;
    if (int'(a[4:0]) >= NCH)     return a;
    if (int'(a[4:0]) == NCH - 1) return base;
    return a + 6'd1;
  endfunction

  assign addr_nx = inc_mode ? next_addr(addr) : addr;
`else
  assign addr_nx = addr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // SSEL rise takes priority over a coincident SCK rise, so a finishing word is dropped.
  always_comb begin
    state_nx  = state;
    cmd_done  = 1'b0;
    word_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (ssel_fall) state_nx = CMD;
      end
      CMD: begin
        if (ssel_rise) begin
          state_nx = IDLE;
        end else if (sck_rise && bit_cnt == 3'd7) begin
          state_nx = DATA;
          cmd_done = 1'b1;
        end
      end
      DATA: begin
        if (ssel_rise)
          state_nx = IDLE;
        else if (sck_rise && bit_cnt == 3'd7 && byte_cnt == LAST_BYTE)
          word_done = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ssel_fall) snap <= rd_val;
    if (sck_rise)  asm_word <= word_in[DW-2:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      addr       <= '0;
      rd_mode    <= 1'b0;
      skip_shift <= 1'b0;
      tx         <= '0;
      wr_val     <= '0;
      wr_stb     <= 1'b0;
      wr_addr    <= '0;
`ifdef SPI_REGBANK_AUTOINC_EN
      inc_mode   <= 1'b0;
`endif
    end else begin
      wr_stb <= 1'b0;

      if (ssel_fall || ssel_rise) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else if (state != IDLE && sck_rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (state == DATA && bit_cnt == 3'd7)
          byte_cnt <= (byte_cnt == LAST_BYTE) ? 2'd0 : byte_cnt + 2'd1;
      end

      // The fall right after a load must not shift, or the word MSB would be lost.
      if (cmd_done) begin
        addr       <= cmd_addr;
        rd_mode    <= cmd_rd;
        tx         <= read_word(cmd_addr);
        skip_shift <= 1'b1;
`ifdef SPI_REGBANK_AUTOINC_EN
        inc_mode   <= asm_word[CMD_INC_BIT-1];
`endif
      end else if (word_done) begin
        if (!rd_mode && addr < RD_BASE) begin
          for (int k = 0; k < NCH; k++) begin
            if (addr[4:0] == 5'(k)) begin
              wr_val[k*DW +: DW] <= word_in;
              wr_stb             <= 1'b1;
              wr_addr            <= addr[4:0];
            end
          end
        end
        addr       <= addr_nx;
        tx         <= read_word(addr_nx);
        skip_shift <= 1'b1;
      end else if (state == DATA && sck_fall) begin
        if (skip_shift) skip_shift <= 1'b0;
        else            tx <= {tx[DW-2:0], 1'b0};
      end
    end
  end

  assign spi.miso = (state == DATA) && rd_mode && tx[DW-1];

endmodule

// File: tb/tb_spi_regbank.sv
// Directed bench for spi_regbank: an 8x8-bit and an 8x16-bit instance share SCK/MOSI.
module tb_spi_regbank;

`ifdef SPI_REGBANK_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic sck = 1'b0, mosi = 1'b0, ssel8 = 1'b1, ssel16 = 1'b1;
  bit   use16 = 1'b0;

  logic [63:0]  rd8  = '0;
  logic [127:0] rd16 = '0;
  logic [63:0]  wv8;
  logic [127:0] wv16;
  logic         stb8, stb16;
  logic [4:0]   wa8, wa16;

  int n_checks = 0, n_errors = 0;
  int stb_cnt8 = 0, stb_cnt16 = 0;
  logic [4:0] seen8 = '0, seen16 = '0;

  spi_regbank_if if8();
  spi_regbank_if if16();

  assign if8.sck   = sck;
  assign if8.mosi  = mosi;
  assign if8.ssel  = ssel8;
  assign if16.sck  = sck;
  assign if16.mosi = mosi;
  assign if16.ssel = ssel16;

  always #5 clk = ~clk;

  spi_regbank #(.NCH(8), .DW(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .spi(if8.slave),
    .wr_val(wv8), .rd_val(rd8), .wr_stb(stb8), .wr_addr(wa8)
  );

  spi_regbank #(.NCH(8), .DW(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .spi(if16.slave),
    .wr_val(wv16), .rd_val(rd16), .wr_stb(stb16), .wr_addr(wa16)
  );

  always @(posedge clk) begin
    if (stb8)  begin stb_cnt8  <= stb_cnt8 + 1;  seen8  <= wa8;  end
    if (stb16) begin stb_cnt16 <= stb_cnt16 + 1; seen16 <= wa16; end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One byte, MSB first; MISO sampled at the host's SCK rise.
  task automatic xfer(input logic [7:0] tb, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = tb[i];
      #80;
      sck = 1'b1;
      rx[i] = use16 ? if16.miso : if8.miso;
      #80;
      sck = 1'b0;
    end
  endtask

  task automatic sel_on();
    if (use16) ssel16 = 1'b0;
    else       ssel8  = 1'b0;
    #160;
  endtask

  task automatic sel_off();
    #80;
    ssel8  = 1'b1;
    ssel16 = 1'b1;
    #300;
  endtask

  // Full transaction: bytes packed MSB-first in 'bytes', n bytes in total (cmd included).
  task automatic txn(input bit sel, input logic [47:0] bytes, input int n,
                     output logic [7:0] cmd_rx, output logic [31:0] rxw);
    logic [7:0] r;
    use16 = sel;
    rxw   = '0;
    sel_on();
    for (int k = 0; k < n; k++) begin
      xfer(bytes[47-8*k -: 8], 8, r);
      if (k == 0) cmd_rx = r;
      else        rxw = {rxw[23:0], r};
    end
    sel_off();
  endtask

  logic [7:0]  crx, r;
  logic [31:0] rxw;
  int          s8, s16;

  initial begin
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    check("reset_wr_val8",  wv8, 64'h0);
    check("reset_wr_val16", wv16[63:0], 64'h0);
    check("reset_miso8",    64'(if8.miso), 64'h0);
    check("reset_miso16",   64'(if16.miso), 64'h0);
    check("reset_stb",      64'(stb_cnt8 + stb_cnt16), 64'h0);

    // 8-bit write to channel 3, then read it back
    txn(1'b0, {8'h03, 8'h5A, 32'h0}, 2, crx, rxw);
    check("wr03_val",    wv8, 64'h0000_0000_5A00_0000);
    check("wr03_stbcnt", 64'(stb_cnt8), 64'd1);
    check("wr03_addr",   64'(seen8), 64'd3);

    txn(1'b0, {8'h83, 8'h00, 32'h0}, 2, crx, rxw);
    check("rd83_cmd_miso", 64'(crx), 64'h0);
    check("rd83_data",     64'(rxw[7:0]), 64'h5A);

    // Snapshot: ch2 changes after SSEL fall but before the command completes
    rd8[23:16] = 8'h77;
    use16 = 1'b0;
    sel_on();
    rd8[23:16] = 8'h11;
    xfer(8'hA2, 8, r);
    xfer(8'h00, 8, r);
    sel_off();
    check("snap_held", 64'(r), 64'h77);
    txn(1'b0, {8'hA2, 8'h00, 32'h0}, 2, crx, rxw);
    check("snap_refresh", 64'(rxw[7:0]), 64'h11);

    // Partial data byte is discarded
    s8 = stb_cnt8;
    use16 = 1'b0;
    sel_on();
    xfer(8'h01, 8, r);
    xfer(8'hFF, 5, r);
    sel_off();
    check("partial_val",    wv8, 64'h0000_0000_5A00_0000);
    check("partial_nostb",  64'(stb_cnt8), 64'(s8));
    txn(1'b0, {8'h01, 8'hC3, 32'h0}, 2, crx, rxw);
    check("after_partial_val",  wv8, 64'h0000_0000_5A00_C300);
    check("after_partial_stb",  64'(stb_cnt8), 64'(s8 + 1));
    check("after_partial_addr", 64'(seen8), 64'd1);

    // Unmapped read and read-region write
    txn(1'b0, {8'h90, 8'h00, 32'h0}, 2, crx, rxw);
    check("unmapped_rd", 64'(rxw[7:0]), 64'h0);
    s8 = stb_cnt8;
    txn(1'b0, {8'h21, 8'hEE, 32'h0}, 2, crx, rxw);
    check("wr21_nostb", 64'(stb_cnt8), 64'(s8));
    check("wr21_val",   wv8, 64'h0000_0000_5A00_C300);

    // 16-bit burst write from ch6 across the wrap point
    s16 = stb_cnt16;
    txn(1'b1, {8'h46, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h55}, 6, crx, rxw);
    check("burst_partial_word_stb", 64'(stb_cnt16), 64'(s16 + 2));
    txn(1'b1, {8'h46, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00}, 5, crx, rxw);
    use16 = 1'b1;
    sel_on();
    xfer(8'h46, 8, r);
    xfer(8'h12, 8, r); xfer(8'h34, 8, r);
    xfer(8'hAB, 8, r); xfer(8'hCD, 8, r);
    xfer(8'h55, 8, r); xfer(8'h66, 8, r);
    sel_off();
    check("burst_ch6", 64'(wv16[6*16 +: 16]), AUTOINC ? 64'h1234 : 64'h5566);
    check("burst_ch7", 64'(wv16[7*16 +: 16]), AUTOINC ? 64'hABCD : 64'h0000);
    check("burst_ch0", 64'(wv16[0 +: 16]),    AUTOINC ? 64'h5566 : 64'h0000);
    check("burst_stbcnt", 64'(stb_cnt16), 64'(s16 + 2 + 2 + 3));
    check("burst_last_addr", 64'(seen16), AUTOINC ? 64'd0 : 64'd6);

    // 16-bit burst reads: write region from ch6, read region from ch7 with wrap
    txn(1'b1, {8'hC6, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 5, crx, rxw);
    check("rdC6_cmd_miso", 64'(crx), 64'h0);
    check("rdC6_burst", 64'(rxw), AUTOINC ? 64'h1234_ABCD : 64'h5566_5566);
    rd16[7*16 +: 16] = 16'h0F0F;
    rd16[0 +: 16]    = 16'hBEEF;
    txn(1'b1, {8'hE7, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 5, crx, rxw);
    check("rdE7_burst", 64'(rxw), AUTOINC ? 64'h0F0F_BEEF : 64'h0F0F_0F0F);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_regbank.md
# spi_regbank

SPI-slave register bank that lets the Raspberry Pi host write display/control values into the FPGA and read back status inputs (quadrature counts, keypad bits). It generalises the existing single-value SPI slave to NCH channels of DW bits, with addressed read/write, multi-byte words, coherent input snapshots and burst access. It sits between the SPI pins and the graph/keypad/quad blocks in `top`.

## Interface
- `NCH`, 8: number of channels per region; 1..32.
- `DW`, 8: channel width in bits; a multiple of 8, 8..32.
- `CLK`  in  1  system clock; must be ≥ 8× SCK frequency.
- `RST_N`  in  1  asynchronous active-low reset.
- `SCK`  in  1  SPI clock from host, asynchronous to CLK, mode 0.
- `SSEL`  in  1  SPI chip select, active low, asynchronous.
- `MOSI`  in  1  host → FPGA data, MSB first.
- `MISO`  out  1  FPGA → host data, MSB first.
- `wr_val`  out  NCH*DW  write-region registers; channel k at bits [k*DW +: DW].
- `rd_val`  in  NCH*DW  read-only status inputs, same packing.
- `wr_stb`  out  1  one-CLK pulse when a write-region word commits.
- `wr_addr`  out  5  channel index of the committed word; valid with `wr_stb`.

## Operation
- SCK, SSEL, MOSI pass through a 3-flop synchroniser. Edge detection on the synchronised signals; all logic runs on CLK.
- Transaction = SSEL low. First byte is the command: bit7 R/nW (1 = read), bit6 auto-increment, bits5:0 address.
- Address map: 0x00..NCH-1 is the write region (R/W, backed by `wr_val`). 0x20..0x20+NCH-1 is the read region (RO, from the snapshot). Any other address: writes ignored, reads return 0.
- Snapshot: all of `rd_val` is latched on the CLK after the synchronised SSEL falling edge. Every read in the transaction returns snapshot data.
- Each word is DW/8 bytes, most-significant byte first.
- Write:
  - Bytes shift into an assembly register.
  - When the last byte of a word completes, the word is stored to the addressed channel.
  - `wr_stb` pulses with `wr_addr`.
  - A write to the read region or an unmapped address gives no store and no strobe.
- Read: at each word boundary, the addressed word is loaded into the output shifter. Its MSB appears on MISO before the first SCK rise of the next byte.
- Auto-increment (bit6 = 1): after each word the address advances, wrapping modulo NCH inside its region. With bit6 = 0, the address holds.
- State machine:
  - IDLE → CMD on SSEL fall.
  - CMD → DATA after 8 bits.
  - DATA stays in DATA until SSEL rises.
  - Any state → IDLE on SSEL rise.
- Partial byte or partial word at SSEL rise is discarded, with no store.
- MISO is 0 in IDLE and during the command byte.

## Timing
- Reset values: `wr_val` = 0, `MISO` = 0, `wr_stb` = 0, `wr_addr` = 0, state IDLE, bit/byte counters 0.
- Input-to-internal latency: 3 CLK for any pin change.
- MOSI is sampled on the synchronised SCK rising edge. MISO shifts on the synchronised SCK falling edge.
- Write commit: `wr_val` updates and `wr_stb` asserts 1 CLK after the rise-edge detect of the word's last bit. `wr_stb` is exactly 1 CLK wide.
- Read load: the shifter loads 1 CLK after the rise-edge detect of the previous byte's bit 0.
- Simultaneous SSEL rise and the last SCK rise in the same CLK: SSEL wins and the word is discarded.
- Reset mid-transaction aborts immediately. The host must re-assert SSEL.

## Configuration
- `SPI_REGBANK_AUTOINC_EN` defined: command bit6 selects auto-increment as above.
- Not defined: bit6 is ignored, the address never advances, and the increment/wrap logic is removed.

## Structure
- Package `spi_regbank_pkg`:
  - command bit positions (`CMD_RD_BIT` = 7, `CMD_INC_BIT` = 6)
  - `RD_BASE` = 6'h20
  - state enum {IDLE, CMD, DATA}
- Sub-module `spi_sync_edge`: a 3-flop synchroniser with rise/fall pulse outputs, instantiated for SCK and SSEL. MOSI uses the same synchroniser without edge outputs.

## Test plan
- Reset, then idle: all `wr_val` = 0, MISO = 0, no `wr_stb`.
- NCH = 8, DW = 8: write cmd 0x03, data 0x5A → `wr_val[31:24]` = 0x5A, one `wr_stb` with `wr_addr` = 3. Read cmd 0x83 plus a dummy byte → MISO returns 0x5A.
- DW = 16, auto-increment on: cmd 0x46, data 0x12 0x34 0xAB 0xCD → ch6 = 0x1234, ch7 = 0xABCD, two strobes. A further word wraps to ch0.
- `rd_val` ch2 = 0x77 at SSEL fall, changed to 0x11 mid-transaction: cmd 0xA2 → reads 0x77.
- Write cmd 0x01, SSEL deasserted after 5 data bits → ch1 unchanged, no strobe. The next transaction works normally.
- Unmapped cmd 0x90 plus a dummy byte → MISO 0x00. Write to 0x21 → no strobe, `wr_val` unchanged.
